instr_fetch_unit: RTL

Program-counter register and instruction-fetch sequencer for the multi-cycle CPU core. Holds the architectural PC and issues a request/acknowledge read to instruction memory. Presents the fetched instruction to decode until the core signals retirement. On retirement it loads `pc_candidate`, the next-PC value computed downstream by the PC candidate generation stage, and starts the next fetch.

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/fetch_timeout_counter.sv | 41 ++++
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU package: datapath word width and the fetch sequencer state
// encoding used by the instruction-fetch stage and its helpers.
package instr_fetch_unit_pkg;

  // Architectural word / word-address width shared by the datapath stages.
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;

  // Width of the fetch wait counter; wide enough for limits up to 255.
  localparam int TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_HOLD,
    FETCH_FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Wait-cycle counter for the fetch sequencer.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clear      : zero the count (asserted on the edge that enters WAIT)
//   enable     : current cycle is a WAIT cycle without an acknowledge
//   limit      : number of ack-less cycles tolerated before expiry
//   expired    : this enabled cycle is the limit-th ack-less cycle
module fetch_timeout_counter
  import instr_fetch_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  localparam logic [TIMEOUT_W:0] ONE = 1;

  logic [TIMEOUT_W-1:0] count;
  logic [TIMEOUT_W:0]   count_inc;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // count holds the ack-less cycles already completed, so the current cycle
  // is number count+1; widened by one bit so the compare cannot overflow.
  assign count_inc = {1'b0, count} + ONE;
  assign expired   = enable && (count_inc >= {1'b0, limit});

endmodule

// File: rtl/instr_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Holds the architectural PC, reads instruction memory with a req/ack
// handshake, presents the fetched word to decode until retirement, then
// loads the downstream next-PC candidate and fetches again.
// Ports:
//   clk, reset    : clock and asynchronous active-high reset
//   pc_candidate  : next PC, sampled only on the retirement edge
//   advance       : current instruction retires this cycle (HOLD only)
//   pc            : architectural PC of the held / in-flight instruction
//   imem_req/addr : memory read request and word address (addr == pc)
//   imem_ack/rdata/err : memory response, rdata/err qualified by ack
//   instr, instr_valid : registered instruction word and its valid flag
//   fetch_fault   : sticky fault (bus error or fetch timeout)
//   retired_count : retirement counter, wraps modulo 2^32
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_candidate,
  input  logic            advance,
  output logic [XLEN-1:0] pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_err,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic            fetch_fault,
  output logic [XLEN-1:0] retired_count
);

  fetch_state_t state;
  logic         wait_clear;
  logic         wait_enable;
  logic         timeout_expired;

  // The counter restarts on every edge that enters WAIT and only advances
  // while a request is outstanding and unanswered.
  assign wait_clear  = (state == FETCH_IDLE) || ((state == FETCH_HOLD) && advance);
  assign wait_enable = (state == FETCH_WAIT) && !imem_ack;

  fetch_timeout_counter u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (wait_clear),
    .enable  (wait_enable),
    .limit   (TIMEOUT_W'(TIMEOUT)),
    .expired (timeout_expired)
  );

  // pc only changes on the retirement edge, so the address is a plain copy.
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FETCH_IDLE;
      pc            <= PC_RESET;
      instr         <= '0;
      instr_valid   <= 1'b0;
      imem_req      <= 1'b0;
      fetch_fault   <= 1'b0;
      retired_count <= '0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          state    <= FETCH_WAIT;
          imem_req <= 1'b1;
        end

        FETCH_WAIT: begin
          // An ack in the timeout cycle still completes the fetch.
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (imem_err) begin
              state       <= FETCH_FAULT;
              fetch_fault <= 1'b1;
            end else begin
              state       <= FETCH_HOLD;
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
            end
          end else if (timeout_expired) begin
            state       <= FETCH_FAULT;
            imem_req    <= 1'b0;
            fetch_fault <= 1'b1;
          end
        end

        FETCH_HOLD: begin
          if (advance) begin
            state         <= FETCH_WAIT;
            pc            <= pc_candidate;
            retired_count <= retired_count + 1'b1;
            instr_valid   <= 1'b0;
            imem_req      <= 1'b1;
          end
        end

        FETCH_FAULT: begin
          // Absorbing: only reset leaves this state.
          state <= FETCH_FAULT;
        end

        default: begin
          state <= FETCH_IDLE;
        end
      endcase
    end
  end

endmodule
